// File: rtl/rca_ft_pkg.sv
// Shared definitions for the ripple-carry-adder fault-test controller:
// FSM state encoding, slice count and pattern-index width.
package rca_ft_pkg;

  localparam int NSLICE = 4;
  localparam int LIW    = 3;

  // first_slice value reported when no slice has faulted
  localparam logic [2:0] NO_FAIL = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    APPLY  = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/rca_bist_ctrl_if.sv
// Signal bundle between a BIST requester and the rca_bist_ctrl block.
//
// Handshake: start is a level request that the controller samples only while
// idle (busy=0); once accepted, busy stays high from CLEAR through DONE and
// further start levels are ignored. done is a single-cycle completion pulse,
// and the result signals are valid from that cycle until the next done.
// abort cancels a run in any busy state except DONE. cs_in is taken only in
// the SAMPLE cycle of each pattern.
interface rca_bist_ctrl_if #(
  parameter int SW = 2
);
  import rca_ft_pkg::*;

  logic              start;
  logic              abort;
  logic [SW-1:0]     settle;
  logic [NSLICE-1:0] cs_in;
  logic [LIW-1:0]    lut_i;
  logic              mon_clr;
  logic              busy;
  logic              done;
  logic [NSLICE-1:0] fault_map;
  logic              fail;
  logic [2:0]        first_slice;
  logic [2:0]        first_pat;

  // requester side
  modport master (
    output start, abort, settle, cs_in,
    input  lut_i, mon_clr, busy, done, fault_map, fail, first_slice, first_pat
  );

  // controller side
  modport slave (
    input  start, abort, settle, cs_in,
    output lut_i, mon_clr, busy, done, fault_map, fail, first_slice, first_pat
  );

endinterface

// File: rtl/rca_bist_ctrl.sv
// BIST sequencer for a 4-slice ripple-carry adder: steps the pattern LUT
// through NPAT entries, waits a programmable settle time per pattern, collects
// the sticky per-slice fault flags and publishes a summary at the end of a run.
module rca_bist_ctrl
  import rca_ft_pkg::*;
#(
  parameter int NPAT = 8,
  parameter int SW   = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [SW-1:0]     settle,
  input  logic [NSLICE-1:0] cs_in,
  output logic [LIW-1:0]    lut_i,
  output logic              mon_clr,
  output logic              busy,
  output logic              done,
  output logic [NSLICE-1:0] fault_map,
  output logic              fail,
  output logic [2:0]        first_slice,
  output logic [2:0]        first_pat,
  output state_t            fsm_state
);

  localparam logic [LIW-1:0] LAST_PAT = LIW'(NPAT - 1);

  state_t            state;
  state_t            state_n;
  logic [LIW-1:0]    pat_cnt;
  logic [SW-1:0]     wait_cnt;
  logic [NSLICE-1:0] work_map;
  logic [LIW-1:0]    work_pat;
  logic [NSLICE-1:0] samp_map;
  logic [LIW-1:0]    samp_pat;
  logic [NSLICE-1:0] fault_map_r;
  logic [LIW-1:0]    first_pat_r;

  // Values the working state takes when the current cycle is a SAMPLE.
  // The working map stays zero until the first faulty sample, so a zero map
  // means the first-pattern capture has not happened yet.
  always_comb begin
    samp_map = work_map | cs_in;
    samp_pat = work_pat;
    if (work_map == '0 && cs_in != '0) samp_pat = pat_cnt;
  end

  // Next-state logic; abort wins everywhere except DONE, which always retires.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && !abort) state_n = CLEAR;
      CLEAR:   state_n = abort ? IDLE : APPLY;
      APPLY:   if (abort)                  state_n = IDLE;
               else if (settle == '0)      state_n = SAMPLE;
               else                        state_n = SETTLE;
      SETTLE:  if (abort)                  state_n = IDLE;
               else if (wait_cnt == SW'(1)) state_n = SAMPLE;
      SAMPLE:  if (abort)                  state_n = IDLE;
               else if (pat_cnt == LAST_PAT) state_n = DONE;
               else                        state_n = APPLY;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, counters, working accumulators and published results.
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      pat_cnt     <= '0;
      wait_cnt    <= '0;
      work_map    <= '0;
      work_pat    <= '0;
      fault_map_r <= '0;
      first_pat_r <= '0;
    end else begin
      state <= state_n;
      case (state)
        CLEAR: begin
          pat_cnt  <= '0;
          wait_cnt <= '0;
          work_map <= '0;
          work_pat <= '0;
        end
        APPLY:  wait_cnt <= settle;
        SETTLE: wait_cnt <= wait_cnt - SW'(1);
        SAMPLE: begin
          if (!abort) begin
            work_map <= samp_map;
            work_pat <= samp_pat;
            if (pat_cnt != LAST_PAT) pat_cnt <= pat_cnt + LIW'(1);
          end
        end
        default: ;
      endcase
      // results change only on the edge into DONE, so they are valid with done
      if (state == SAMPLE && state_n == DONE) begin
        fault_map_r <= samp_map;
        first_pat_r <= samp_pat;
      end
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    mon_clr = (state == CLEAR);
    busy    = (state != IDLE);
    done    = (state == DONE);
    lut_i   = '0;
    if (state == APPLY || state == SETTLE || state == SAMPLE) lut_i = pat_cnt;
  end

  // Result summary: lowest faulty slice wins the priority encode.
  always_comb begin
    fault_map   = fault_map_r;
    first_pat   = first_pat_r;
    fail        = |fault_map_r;
    first_slice = NO_FAIL;
    for (int k = NSLICE - 1; k >= 0; k--) begin
      if (fault_map_r[k]) first_slice = 3'(k);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_rca_bist_ctrl.sv
// Directed bench for rca_bist_ctrl: table of full runs plus hand-written
// abort / clr / start-while-busy sequences.
module tb_rca_bist_ctrl;
  import rca_ft_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  rca_bist_ctrl_if #(.SW(2)) bus();
  state_t fsm_state;

  rca_bist_ctrl #(.NPAT(8), .SW(2)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (bus.start),
    .abort       (bus.abort),
    .settle      (bus.settle),
    .cs_in       (bus.cs_in),
    .lut_i       (bus.lut_i),
    .mon_clr     (bus.mon_clr),
    .busy        (bus.busy),
    .done        (bus.done),
    .fault_map   (bus.fault_map),
    .fail        (bus.fail),
    .first_slice (bus.first_slice),
    .first_pat   (bus.first_pat),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  // expected published results of the last completed run
  logic [3:0] exp_map_q;
  logic [2:0] exp_slice_q;
  logic [2:0] exp_pat_q;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_results(input string tag);
    check({tag, ".fault_map"},   8'(bus.fault_map),   8'(exp_map_q));
    check({tag, ".fail"},        8'(bus.fail),        8'(exp_map_q != 4'd0));
    check({tag, ".first_slice"}, 8'(bus.first_slice), 8'(exp_slice_q));
    check({tag, ".first_pat"},   8'(bus.first_pat),   8'(exp_pat_q));
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  settle;
    logic [31:0] cs_pat;     // nibble p = cs_in during pattern p SAMPLE
    bit          noise;      // drive 4'hF on cs_in in every non-SAMPLE cycle
    bit          abort_done; // raise abort in the DONE cycle
    int          done_cyc;
    logic [3:0]  exp_map;
    logic [2:0]  exp_slice;
    logic [2:0]  exp_pat;
  } vec_t;

  vec_t vecs[5];

  // Full run; cycle n is the cycle after edge n, edge 0 samples start.
  task automatic run_vec(input vec_t v, input string tag);
    int s, k, p, ph;
    logic [3:0] cs;
    logic [2:0] exp_lut;
    s = int'(v.settle);
    bus.settle = v.settle;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    for (int n = 1; n <= v.done_cyc; n++) begin
      if (n > 1) step();
      cs      = v.noise ? 4'hF : 4'h0;
      exp_lut = 3'd0;
      if (n >= 2 && n < v.done_cyc) begin
        k  = n - 2;
        p  = k / (2 + s);
        ph = k % (2 + s);
        exp_lut = p[2:0];
        if (ph == 1 + s) cs = v.cs_pat[4*p +: 4];
      end
      bus.cs_in = cs;
      if (n == v.done_cyc && v.abort_done) bus.abort = 1'b1;
      check({tag, ".busy"},    8'(bus.busy),    8'd1);
      check({tag, ".mon_clr"}, 8'(bus.mon_clr), 8'(n == 1));
      check({tag, ".lut_i"},   8'(bus.lut_i),   8'(exp_lut));
      check({tag, ".done"},    8'(bus.done),    8'(n == v.done_cyc));
      if (n < v.done_cyc) check({tag, ".held_map"}, 8'(bus.fault_map), 8'(exp_map_q));
    end
    exp_map_q   = v.exp_map;
    exp_slice_q = v.exp_slice;
    exp_pat_q   = v.exp_pat;
    check_results({tag, ".done"});
    for (int i = 0; i < 3; i++) begin
      step();
      bus.abort = 1'b0;
      bus.cs_in = 4'h0;
      check({tag, ".idle_busy"}, 8'(bus.busy), 8'd0);
      check({tag, ".idle_done"}, 8'(bus.done), 8'd0);
      check_results({tag, ".idle"});
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //          settle cs_pat        noise abort_done done map     slice pat
    vecs[0] = '{2'd0, 32'h0000_0000, 1'b0, 1'b0, 18, 4'b0000, 3'd4, 3'd0};
    vecs[1] = '{2'd3, 32'h0040_0000, 1'b1, 1'b0, 42, 4'b0100, 3'd2, 3'd5};
    vecs[2] = '{2'd0, 32'hAAAA_AA00, 1'b0, 1'b0, 18, 4'b1010, 3'd1, 3'd2};
    vecs[3] = '{2'd1, 32'h8000_1000, 1'b1, 1'b1, 26, 4'b1001, 3'd0, 3'd3};
    vecs[4] = '{2'd2, 32'h0000_0006, 1'b0, 1'b0, 34, 4'b0110, 3'd1, 3'd0};

    clr        = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.settle = 2'd0;
    bus.cs_in  = 4'h0;
    step();
    step();
    clr = 1'b0;
    exp_map_q   = 4'd0;
    exp_slice_q = NO_FAIL;
    exp_pat_q   = 3'd0;
    check("rst.busy",    8'(bus.busy),    8'd0);
    check("rst.done",    8'(bus.done),    8'd0);
    check("rst.mon_clr", 8'(bus.mon_clr), 8'd0);
    check("rst.lut_i",   8'(bus.lut_i),   8'd0);
    check_results("rst");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // abort during pattern 4 (APPLY at cycle 10), faults seen beforehand
    bus.settle = 2'd0;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) step();
      bus.cs_in = 4'hF;
    end
    check("abort.lut_i_pat4", 8'(bus.lut_i), 8'd4);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.cs_in = 4'h0;
    check("abort.busy",    8'(bus.busy),    8'd0);
    check("abort.done",    8'(bus.done),    8'd0);
    check("abort.lut_i",   8'(bus.lut_i),   8'd0);
    check("abort.state",   8'(fsm_state),   8'(IDLE));
    check_results("abort");
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort.no_done", 8'(bus.done), 8'd0);
    end
    run_vec(vecs[0], "after_abort");

    // start held high during a run: single done, no queued second run
    bus.settle = 2'd0;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    for (int n = 1; n <= 18; n++) begin
      if (n > 1) step();
      bus.start = (n >= 3 && n < 18);
      check("busy_start.done", 8'(bus.done), 8'(n == 18));
    end
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_start.no_queue", 8'(bus.busy), 8'd0);
    end

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    check("start_abort.busy",    8'(bus.busy),    8'd0);
    check("start_abort.mon_clr", 8'(bus.mon_clr), 8'd0);
    step();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_abort.busy2", 8'(bus.busy), 8'd0);

    // clr during SETTLE of pattern 0 (settle=3), with start/abort also high
    exp_map_q   = 4'b1010;
    bus.settle  = 2'd3;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    step();
    step();
    check("clr.in_settle", 8'(fsm_state), 8'(SETTLE));
    clr       = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    exp_map_q   = 4'd0;
    exp_slice_q = NO_FAIL;
    exp_pat_q   = 3'd0;
    check("clr.state",   8'(fsm_state),   8'(IDLE));
    check("clr.busy",    8'(bus.busy),    8'd0);
    check("clr.done",    8'(bus.done),    8'd0);
    check("clr.mon_clr", 8'(bus.mon_clr), 8'd0);
    check("clr.lut_i",   8'(bus.lut_i),   8'd0);
    check_results("clr");
    clr       = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("clr.no_done", 8'(bus.done), 8'd0);
      check("clr.idle",    8'(bus.busy), 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop so the run cannot hang
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
